// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-ported test RAM: fixed priority to m0, with m1 forced in after MAX_WAIT losses.
// Latency: a request seen at posedge N gets ready during cycle N+2; each access takes 3 cycles (IDLE, ACCESS, DONE).
// Backpressure: a requester holds req and its fields stable until its one-cycle ready pulse; the loser simply waits.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ready,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ready,
    output logic                  owner,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt, wait_cnt_nxt;
    logic                    any_req;
    logic                    grant_m1;
    logic                    owner_nxt;
    logic                    mem_wen_nxt, mem_ren_nxt;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
    logic [DATA_WIDTH-1:0]   mem_wdata_nxt;
    logic [DATA_WIDTH-1:0]   m0_rdata_nxt, m1_rdata_nxt;
    logic                    m0_ready_nxt, m1_ready_nxt;

    assign any_req  = m0_req | m1_req;
    // m1 wins when it is alone, or when it has already lost WAIT_LIMIT times in a row.
    assign grant_m1 = m1_req & (~m0_req | (wait_cnt == WAIT_LIMIT));

    // State and every output are registered together so reset drops them all at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            owner     <= 1'b0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            owner     <= owner_nxt;
            mem_wen   <= mem_wen_nxt;
            mem_ren   <= mem_ren_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            m0_rdata  <= m0_rdata_nxt;
            m1_rdata  <= m1_rdata_nxt;
            m0_ready  <= m0_ready_nxt;
            m1_ready  <= m1_ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_nxt  = wait_cnt;
        owner_nxt     = owner;
        mem_wen_nxt   = 1'b0;
        mem_ren_nxt   = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        m0_rdata_nxt  = m0_rdata;
        m1_rdata_nxt  = m1_rdata;
        m0_ready_nxt  = 1'b0;
        m1_ready_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!m1_req || grant_m1) begin
                    wait_cnt_nxt = '0;
                end else if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
                if (any_req) begin
                    owner_nxt = grant_m1;
                    if (grant_m1) begin
                        mem_addr_nxt  = m1_addr;
                        mem_wdata_nxt = m1_wdata;
                        mem_wen_nxt   = m1_we;
                        mem_ren_nxt   = ~m1_we;
                    end else begin
                        mem_addr_nxt  = m0_addr;
                        mem_wdata_nxt = m0_wdata;
                        mem_wen_nxt   = m0_we;
                        mem_ren_nxt   = ~m0_we;
                    end
                end
            end
            ACCESS: begin
                // The RAM updated mem_rdata on the negedge inside this cycle.
                if (mem_ren) begin
                    if (owner) m1_rdata_nxt = mem_rdata;
                    else       m0_rdata_nxt = mem_rdata;
                end
                if (owner) m1_ready_nxt = 1'b1;
                else       m0_ready_nxt = 1'b1;
            end
            DONE: begin
                owner_nxt = 1'b0;
            end
            default: begin
                owner_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboarded bench for ram_arbiter: directed accesses push expected grants and read data; a negedge monitor checks them.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        owner, mem_wen, mem_ren;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        own;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    grant_t      gq[$];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] ram[logic [29:0]];
    logic        prev_strobe = 1'b0;

    ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .owner(owner), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Word-wide RAM acting on the negedge, like the real test RAM.
    always @(negedge clk) begin
        if (mem_wen) ram[mem_addr[31:2]] = mem_wdata;
        if (mem_ren) mem_rdata = ram.exists(mem_addr[31:2]) ? ram[mem_addr[31:2]] : 32'h0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_strobe <= 1'b0;
        end else begin
            if (mem_wen || mem_ren) begin
                grant_t g;
                check("strobe_one_cycle", {31'h0, prev_strobe}, 32'h0);
                check("strobe_exclusive", {31'h0, mem_wen & mem_ren}, 32'h0);
                if (gq.size() == 0) begin
                    check("grant_unexpected", 32'h1, 32'h0);
                end else begin
                    g = gq.pop_front();
                    check("grant_owner", {31'h0, owner}, {31'h0, g.own});
                    check("grant_we", {31'h0, mem_wen}, {31'h0, g.we});
                    check("grant_addr", mem_addr, g.addr);
                    if (g.we) check("grant_wdata", mem_wdata, g.wdata);
                end
            end
            prev_strobe <= mem_wen | mem_ren;
            if (m0_ready && m1_ready) check("ready_both", 32'h1, 32'h0);
            if (m0_ready) begin
                if (q0.size() == 0) check("m0_ready_unexpected", 32'h1, 32'h0);
                else check("m0_rdata", m0_rdata, q0.pop_front());
            end
            if (m1_ready) begin
                if (q1.size() == 0) check("m1_ready_unexpected", 32'h1, 32'h0);
                else check("m1_rdata", m1_rdata, q1.pop_front());
            end
        end
    end

    task automatic expect_grant(input logic own, input logic we, input logic [31:0] a, input logic [31:0] d);
        grant_t g;
        g.own = own; g.we = we; g.addr = a; g.wdata = d;
        gq.push_back(g);
    endtask

    task automatic issue(input int m, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd);
        if (m == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; q0.push_back(exp_rd);
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; q1.push_back(exp_rd);
        end
    endtask

    // Waits for the master's ready, then returns #1 after the DONE->IDLE edge.
    task automatic wait_done(input int m, input int exp_lat, input bit keep);
        int  t0;
        bit  seen;
        t0   = cyc;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (m == 0) ? m0_ready : m1_ready;
        end
        if (!seen) check($sformatf("m%0d_ready_timeout", m), 32'h0, 32'h1);
        else if (exp_lat > 0) check($sformatf("m%0d_latency", m), 32'(cyc - t0), 32'(exp_lat));
        @(posedge clk);
        #1;
        if (!keep) begin
            if (m == 0) m0_req = 1'b0;
            else        m1_req = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_wen"}, {31'h0, mem_wen}, 32'h0);
        check({tag, "_mem_ren"}, {31'h0, mem_ren}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_m0_ready"}, {31'h0, m0_ready}, 32'h0);
        check({tag, "_m1_ready"}, {31'h0, m1_ready}, 32'h0);
        check({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        check({tag, "_m1_rdata"}, m1_rdata, 32'h0);
        check({tag, "_owner"}, {31'h0, owner}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        ram[30'h80 >> 2]  = 32'hDEADBEEF;
        for (int i = 0; i < 7; i++) ram[30'(32'h100 / 4 + i)] = 32'hA0 + 32'(i);
        ram[30'h200 >> 2] = 32'hB0;
        ram[30'h204 >> 2] = 32'hB1;
        ram[30'h300 >> 2] = 32'hC0;

        #22;
        check_reset_outputs("reset");
        @(posedge clk); #2; reset = 1'b1;

        // 1: m0 write then read back 0x7C
        @(posedge clk); #1;
        issue(0, 1'b1, 32'h7C, 32'h5, 32'h0);
        expect_grant(1'b0, 1'b1, 32'h7C, 32'h5);
        wait_done(0, 2, 1'b0);
        issue(0, 1'b0, 32'h7C, 32'h0, 32'h5);
        expect_grant(1'b0, 1'b0, 32'h7C, 32'h0);
        wait_done(0, 2, 1'b0);
        check("t1_m1_rdata_untouched", m1_rdata, 32'h0);

        // 2: m1 alone reads 0x80
        issue(1, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF);
        expect_grant(1'b1, 1'b0, 32'h80, 32'h0);
        wait_done(1, 2, 1'b0);
        check("t2_m0_rdata_untouched", m0_rdata, 32'h5);

        // 3: continuous contention, forced m1 grant every fourth decision
        expect_grant(1'b0, 1'b0, 32'h100, 32'h0);
        expect_grant(1'b0, 1'b0, 32'h104, 32'h0);
        expect_grant(1'b0, 1'b0, 32'h108, 32'h0);
        expect_grant(1'b1, 1'b0, 32'h200, 32'h0);
        expect_grant(1'b0, 1'b0, 32'h10C, 32'h0);
        expect_grant(1'b0, 1'b0, 32'h110, 32'h0);
        expect_grant(1'b0, 1'b0, 32'h114, 32'h0);
        expect_grant(1'b1, 1'b0, 32'h204, 32'h0);
        fork
            for (int i = 0; i < 6; i++) begin
                issue(0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 32'hA0 + 32'(i));
                wait_done(0, 0, i < 5);
            end
            for (int j = 0; j < 2; j++) begin
                issue(1, 1'b0, 32'h200 + 32'(4 * j), 32'h0, 32'hB0 + 32'(j));
                wait_done(1, 0, j < 1);
            end
        join

        // 4: simultaneous m0 write / m1 read of the same word
        expect_grant(1'b0, 1'b1, 32'h90, 32'h11111111);
        expect_grant(1'b1, 1'b0, 32'h90, 32'h0);
        fork
            begin issue(0, 1'b1, 32'h90, 32'h11111111, 32'hA5); wait_done(0, 2, 1'b0); end
            begin issue(1, 1'b0, 32'h90, 32'h0, 32'h11111111); wait_done(1, 5, 1'b0); end
        join

        // 5: reset during the ACCESS cycle of an m1 write
        issue(1, 1'b1, 32'h94, 32'h22222222, 32'h0);
        expect_grant(1'b1, 1'b1, 32'h94, 32'h22222222);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk);
                seen = mem_wen;
            end
            check("t5_wen_seen", {31'h0, seen}, 32'h1);
        end
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("t5_abort");
        q1.delete();
        m1_req = 1'b0; m1_we = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("t5_no_m1_ready", {31'h0, m1_ready}, 32'h0);
        end
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h7C, 32'h0, 32'h5);
        expect_grant(1'b0, 1'b0, 32'h7C, 32'h0);
        wait_done(0, 2, 1'b0);

        // 6: m1 withdraws for one IDLE decision, so its wait count restarts
        issue(0, 1'b0, 32'h100, 32'h0, 32'hA0);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h300;
        expect_grant(1'b0, 1'b0, 32'h100, 32'h0);
        wait_done(0, 2, 1'b1);
        issue(0, 1'b0, 32'h104, 32'h0, 32'hA1);
        expect_grant(1'b0, 1'b0, 32'h104, 32'h0);
        wait_done(0, 2, 1'b1);
        m1_req = 1'b0;
        issue(0, 1'b0, 32'h108, 32'h0, 32'hA2);
        expect_grant(1'b0, 1'b0, 32'h108, 32'h0);
        wait_done(0, 2, 1'b1);
        expect_grant(1'b0, 1'b0, 32'h10C, 32'h0);
        expect_grant(1'b0, 1'b0, 32'h110, 32'h0);
        expect_grant(1'b0, 1'b0, 32'h114, 32'h0);
        expect_grant(1'b1, 1'b0, 32'h300, 32'h0);
        expect_grant(1'b0, 1'b0, 32'h118, 32'h0);
        fork
            for (int i = 3; i < 7; i++) begin
                issue(0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 32'hA0 + 32'(i));
                wait_done(0, 0, i < 6);
            end
            begin issue(1, 1'b0, 32'h300, 32'h0, 32'hC0); wait_done(1, 0, 1'b0); end
        join

        repeat (5) @(negedge clk);
        check("grant_queue_drained", 32'(gq.size()), 32'h0);
        check("m0_queue_drained", 32'(q0.size()), 32'h0);
        check("m1_queue_drained", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter sharing the single-ported byte-addressed test RAM (32-bit little-endian word port, negedge-updated) between the CPU data side (master 0) and a second requester (master 1, e.g. loader/debug/DMA).
- Sits between requesters and the RAM strobes `ram_write_enable`/`ram_read_enable`/`ram_address`/`ram_in`/`ram_out`.
- Serialises accesses, captures read data per master, and guarantees master 1 cannot be starved.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- MAX_WAIT, 3, consecutive lost arbitrations after which a waiting master 1 is forced to win; 1..15.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-low (0 = reset).
- m0_req  input  1  master 0 request; held with m0_we/m0_addr/m0_wdata stable until m0_ready.
- m0_we  input  1  1 = write, 0 = read.
- m0_addr  input  ADDR_WIDTH  byte address.
- m0_wdata  input  DATA_WIDTH  write data.
- m0_rdata  output  DATA_WIDTH  read data, valid while m0_ready=1, held afterwards.
- m0_ready  output  1  one-cycle completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready: same as master 0.
- owner  output  1  master currently granted; 0 when idle.
- mem_wen  output  1  RAM write strobe.
- mem_ren  output  1  RAM read strobe.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- mem_rdata  input  DATA_WIDTH  RAM read data, updated at negedge of the ACCESS cycle.

Behaviour:
- Reset (async, reset=0): state IDLE; mem_wen=mem_ren=0; mem_addr=0; mem_wdata=0; m0_ready=m1_ready=0; m0_rdata=m1_rdata=0; owner=0; wait_cnt=0. Reset mid-transaction aborts it: strobes drop immediately, no ready is issued.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: at the posedge where any req=1, pick a winner, set owner, and load mem_addr/mem_wdata from the winner. Set mem_wen=we, mem_ren=~we. Go to ACCESS. With no req, stay in IDLE.
- ACCESS: strobes are high for exactly this one cycle. The RAM acts on the negedge. At the next posedge, clear strobes; for a read, capture mem_rdata into the owner's rdata register; pulse the owner's ready. Go to DONE.
- DONE: ready=1 for this cycle only. At the next posedge, clear ready and return to IDLE.
- Latency: req seen at posedge N gives ready high during cycle N+2. Each transaction occupies 3 cycles; back-to-back throughput is 1 access per 3 cycles.
- The non-owner's rdata register and ready are never modified.
- Writes leave the owner's rdata unchanged.
- Handshake: a master may keep req high after ready to request again. It is re-arbitrated in the next IDLE. Dropping req before ready is illegal; behaviour is undefined.
- Arbitration: fixed priority to master 0, except that when wait_cnt == MAX_WAIT and m1_req=1, master 1 wins.
- wait_cnt: increments (saturating at MAX_WAIT) on each IDLE decision where m1_req=1 and master 0 wins. It clears when master 1 is granted or when m1_req=0 in IDLE.
- Only one req asserted: that master wins regardless of wait_cnt.
- Address and data pass through unmodified; there is no alignment check. The RAM handles byte lanes.

Test Plan:
1. Reset, then m0 write addr=0x7C data=0x00000005, then m0 read 0x7C -> mem_wen high exactly 1 cycle; m0_ready 2 cycles after req; read gives m0_rdata=0x00000005; m1_rdata stays 0.
2. m1 alone reads 0x80 preloaded 0xDEADBEEF -> owner=1 during ACCESS; m1_ready pulse; m1_rdata=0xDEADBEEF; m0 outputs unchanged.
3. m0 and m1 both request continuously, MAX_WAIT=3 -> grant order m0,m0,m0,m1,m0,m0,m0,m1; never 4 consecutive m0 grants while m1 waits.
4. Simultaneous m0 write 0x90=0x11111111 and m1 read 0x90 -> m0 served first; m1 then reads 0x11111111.
5. Assert reset=0 during ACCESS of an m1 write -> mem_wen=0 immediately; no m1_ready; all outputs at reset values; after release, a fresh m0 read completes normally.
6. m0 read pending for 3 cycles, then m1_req=0 for one IDLE decision -> wait_cnt clears to 0 (next contention needs 3 more m0 wins before m1 is forced).
